cpu_sram_axi_bridge: RTL
========================

// Module: cpu_sram_axi_bridge
// PURPOSE
//  Sits directly below the 5-stage CPU core. Converts the core's level-held inst/data SRAM-like requests into single-beat AXI3 transactions.
//  One transaction in flight at a time; data side has priority over inst. Drives stall_o so the pipeline freezes until each access completes.
// PARAMETERS
//  ID_INST  4'd0  ARID used for instruction fetches
//  ID_DATA  4'd1  ARID/AWID used for data loads/stores
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-low (rst==0 resets)
//  inst_req       in   1   fetch request, held high until inst_data_ok
//  inst_addr      in   32  fetch address, word aligned
//  inst_rdata     out  32  fetched word, valid with inst_data_ok
//  inst_data_ok   out  1   one-cycle completion pulse
//  data_req       in   1   load/store request, held high until data_data_ok
//  data_wen       in   4   byte strobes; 4'b0 = load, else store
//  data_addr      in   32  access address
//  data_wdata     in   32  store data
//  data_rdata     out  32  load data, valid with data_data_ok
//  data_data_ok   out  1   one-cycle completion pulse
//  stall_o        out  1   (inst_req&~inst_data_ok)|(data_req&~data_data_ok)
//  arid/araddr/arvalid  out 4/32/1; arready in 1   AXI read address channel
//  rid/rdata/rresp/rvalid in 4/32/2/1; rready out 1   AXI read data channel
//  awid/awaddr/awvalid  out 4/32/1; awready in 1   AXI write address channel
//  wdata/wstrb/wvalid   out 32/4/1; wready in 1    AXI write data channel
//  bid/bresp/bvalid     in 4/2/1;   bready out 1   AXI write response channel
//  arlen/awlen=0, arsize/awsize=3'b010, arburst/awburst=2'b01, wlast=1 (constant ties)
// BEHAVIOUR
//  - FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP. Reset -> IDLE.
//  - Reset values: all valid/ready outputs 0, *_data_ok 0, rdata outputs 0, address/id regs 0.
//  - IDLE: data_req & data_wen!=0 -> latch addr/wdata/wen, WR_ADDR_DATA; data_req load -> RD_ADDR (id=ID_DATA);
//    else inst_req -> RD_ADDR (id=ID_INST). Data wins when both requests are high.
//  - RD_ADDR: arvalid=1 with latched addr/id; on arready -> RD_DATA, arvalid drops the next cycle.
//  - RD_DATA: rready=1; on rvalid: capture rdata, pulse inst_data_ok or data_data_ok (per latched id) next cycle, -> IDLE.
//  - WR_ADDR_DATA: awvalid and wvalid both 1; each dropped independently at its own handshake (aw_done/w_done flags).
//    When both are done -> WR_RESP. Handshakes on the same cycle are legal.
//  - WR_RESP: bready=1; on bvalid pulse data_data_ok, -> IDLE.
//  - Latency (zero-wait slave): load/fetch 3 cycles req->data_ok; store 3 cycles.
//  - data_ok pulse cycle is spent in IDLE and takes no new request (the core drops req that cycle). Min issue spacing is 4 cycles.
//  - rresp/bresp are ignored (no exception path). rid is not checked against the latched id.
//  - Addresses and payload are latched at accept; later changes on the core inputs during a transaction are ignored.
//  - Reset mid-transaction: FSM -> IDLE, all valids dropped. No ready/valid is left asserted.
//  - AXI valid signals never depend combinationally on ready. Valids stay stable until their handshake.
// STRUCTURE
//  - Shared package/defines (lib/defines.vh): state encodings BR_IDLE..BR_WR_RESP, AXI_SIZE_WORD, AXI_BURST_INCR.
//  - One submodule is natural: axi_wr_chan_tracker (aw_done/w_done flags, completion flag).
//  - Everything else lives in this file: FSM, latch regs, read path.
// TESTING
//  1 inst_req=1, addr=0xBFC00000, slave ready at once, rdata=0x24010001 -> araddr=0xBFC00000, arid=0, inst_data_ok pulse with inst_rdata=0x24010001.
//  2 data_req load plus inst_req in the same cycle -> data read issued first (arid=1). The inst fetch follows after data_data_ok.
//  3 store wen=4'b0011, addr=0x80001000, data=0xDEADBEEF; awready 2 cycles late, wready at once -> wvalid drops first, awvalid later; one data_data_ok after bvalid.
//  4 arready held low 5 cycles -> arvalid and araddr stay stable, stall_o stays 1 for the whole wait.
//  5 rst=0 asserted while in RD_DATA -> next cycle state IDLE, rready=0, arvalid=0, no data_ok pulse.
//  6 Back-to-back fetches 0x0,0x4,0x8 with a zero-wait slave -> three inst_data_ok pulses, 4 cycles apart, data returned in order.

Source files
------------

// File: rtl/cpu_sram_axi_bridge_pkg.sv
// cpu_sram_axi_bridge_pkg: shared FSM state encoding and AXI constant ties for the bridge
package cpu_sram_axi_bridge_pkg;
  typedef enum logic [2:0] {
    BR_IDLE,
    BR_RD_ADDR,
    BR_RD_DATA,
    BR_WR_ADDR_DATA,
    BR_WR_RESP
  } br_state_t;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
endpackage

// File: rtl/cpu_sram_axi_bridge_if.sv
// cpu_sram_axi_bridge_if: AXI3 five-channel bundle between the bridge and its slave
// master modport: the bridge drives ar*/aw*/w*, rready and bready
// slave modport: the memory side drives arready/awready/wready and the r*/b* channels
interface cpu_sram_axi_bridge_if;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  logic [3:0] awid;
  logic [31:0] awaddr;
  logic [3:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input arready, rid, rdata, rresp, rvalid, awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awid, awaddr, awlen, awsize, awburst, awvalid,
    input wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/cpu_sram_axi_bridge_wr_tracker.sv
// cpu_sram_axi_bridge_wr_tracker: remembers which of the AW/W handshakes of a store are done
// en_i: high while the bridge is in the write address/data phase; flags clear when low
// aw_hs_i/w_hs_i: handshake seen this cycle; *_done_o: registered flags; done_o: both done by this edge
module cpu_sram_axi_bridge_wr_tracker (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic aw_hs_i,
  input  logic w_hs_i,
  output logic aw_done_o,
  output logic w_done_o,
  output logic done_o
);
  logic aw_done_q, w_done_q, aw_done_d, w_done_d;
  always_comb begin
    aw_done_d = en_i & (aw_done_q | aw_hs_i);
    w_done_d = en_i & (w_done_q | w_hs_i);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
  assign aw_done_o = aw_done_q;
  assign w_done_o = w_done_q;
  // Same-cycle handshakes count, so both may complete on one edge
  assign done_o = aw_done_d & w_done_d;
endmodule

// File: rtl/cpu_sram_axi_bridge.sv
// cpu_sram_axi_bridge: turns the core's level-held inst/data SRAM requests into single-beat AXI3 transfers
// clk/rst: clock and synchronous active-low reset
// inst_*_i/o: fetch request, address, returned word and completion pulse
// data_*_i/o: load/store request, strobes (0 = load), address, store data, load data and completion pulse
// stall_o: freezes the pipeline while any request is outstanding; axi: AXI3 master port
module cpu_sram_axi_bridge
  import cpu_sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  output logic inst_data_ok_o,
  input  logic data_req_i,
  input  logic [3:0] data_wen_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic data_data_ok_o,
  output logic stall_o,
  cpu_sram_axi_bridge_if.master axi
);
  br_state_t state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0] wen_q;
  logic is_data_q, inst_ok_q, data_ok_q;
  logic aw_done, w_done, wr_done, accept, rd_fin, wr_fin;
  // The completion-pulse cycle sits in IDLE but must not take the still-held request
  assign accept = (state_q == BR_IDLE) & ~(inst_ok_q | data_ok_q) & (data_req_i | inst_req_i);
  assign rd_fin = (state_q == BR_RD_DATA) & axi.rvalid;
  assign wr_fin = (state_q == BR_WR_RESP) & axi.bvalid;
  always_comb begin
    state_d = state_q;
    case (state_q)
      BR_IDLE: state_d = !accept ? BR_IDLE : (data_req_i & |data_wen_i) ? BR_WR_ADDR_DATA : BR_RD_ADDR;
      BR_RD_ADDR: state_d = axi.arready ? BR_RD_DATA : BR_RD_ADDR;
      BR_RD_DATA: state_d = axi.rvalid ? BR_IDLE : BR_RD_DATA;
      BR_WR_ADDR_DATA: state_d = wr_done ? BR_WR_RESP : BR_WR_ADDR_DATA;
      BR_WR_RESP: state_d = axi.bvalid ? BR_IDLE : BR_WR_RESP;
      default: state_d = BR_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BR_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wen_q <= '0;
      is_data_q <= 1'b0;
      rdata_q <= '0;
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_ok_q <= rd_fin & ~is_data_q;
      data_ok_q <= (rd_fin & is_data_q) | wr_fin;
      if (rd_fin) rdata_q <= axi.rdata;
      if (accept) begin
        addr_q <= data_req_i ? data_addr_i : inst_addr_i;
        wdata_q <= data_wdata_i;
        wen_q <= data_req_i ? data_wen_i : 4'b0;
        is_data_q <= data_req_i;
      end
    end
  end
  cpu_sram_axi_bridge_wr_tracker u_wr_tracker (
    .clk(clk),
    .rst(rst),
    .en_i(state_q == BR_WR_ADDR_DATA),
    .aw_hs_i(axi.awvalid & axi.awready),
    .w_hs_i(axi.wvalid & axi.wready),
    .aw_done_o(aw_done),
    .w_done_o(w_done),
    .done_o(wr_done)
  );
  assign axi.arid = is_data_q ? ID_DATA : ID_INST;
  assign axi.araddr = addr_q;
  assign axi.arlen = AXI_LEN_SINGLE;
  assign axi.arsize = AXI_SIZE_WORD;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = state_q == BR_RD_ADDR;
  assign axi.rready = state_q == BR_RD_DATA;
  assign axi.awid = ID_DATA;
  assign axi.awaddr = addr_q;
  assign axi.awlen = AXI_LEN_SINGLE;
  assign axi.awsize = AXI_SIZE_WORD;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = (state_q == BR_WR_ADDR_DATA) & ~aw_done;
  assign axi.wdata = wdata_q;
  assign axi.wstrb = wen_q;
  assign axi.wlast = 1'b1;
  assign axi.wvalid = (state_q == BR_WR_ADDR_DATA) & ~w_done;
  assign axi.bready = state_q == BR_WR_RESP;
  assign inst_rdata_o = rdata_q;
  assign data_rdata_o = rdata_q;
  assign inst_data_ok_o = inst_ok_q;
  assign data_data_ok_o = data_ok_q;
  assign stall_o = (inst_req_i & ~inst_ok_q) | (data_req_i & ~data_ok_q);
endmodule
